// File: rtl/reg9b_byte_serializer_if.sv
// Word-in / byte-out stream bundle for reg9b_byte_serializer.
// out_par exists only when REG9B_SER_PARITY_EN is defined.
interface reg9b_byte_serializer_if;
    logic [71:0] d;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
`ifdef REG9B_SER_PARITY_EN
    logic        out_par;

    modport master (
        output d, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_idx, out_last, out_par
    );
    modport slave (
        input  d, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_idx, out_last, out_par
    );
`else
    modport master (
        output d, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_idx, out_last
    );
    modport slave (
        input  d, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_idx, out_last
    );
`endif
endinterface

// File: rtl/reg9b_byte_serializer.sv
// Serializes 72-bit words into 9 bytes with one pending word of buffering.
// Define REG9B_SER_PARITY_EN to add an even-parity bit (out_par) to the byte stream.
module reg9b_byte_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    ce,
    reg9b_byte_serializer_if.slave  bus
);
    localparam int         NBYTES   = 9;
    localparam logic [3:0] LAST_IDX = 4'd8;

    logic [71:0] act_q, act_d;
    logic [71:0] pend_q, pend_d;
    logic [3:0]  idx_q, idx_d;
    logic        act_full_q, act_full_d;
    logic        pend_full_q, pend_full_d;

    logic        in_ready_w;
    logic        out_valid_w;
    logic        accept_w;
    logic        xfer_w;
    logic        end_xfer_w;
    logic [7:0]  lane_w [NBYTES];
    logic [7:0]  byte_sel_w;
    logic [7:0]  out_data_w;

    // Lane k holds the k-th byte in emission order.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            if (MSB_FIRST) begin : g_msb
                assign lane_w[gi] = act_q[8*(NBYTES-1-gi) +: 8];
            end else begin : g_lsb
                assign lane_w[gi] = act_q[8*gi +: 8];
            end
        end
    endgenerate

    always_comb begin
        byte_sel_w = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx_q == 4'(k)) begin
                byte_sel_w = lane_w[k];
            end
        end
    end

    assign in_ready_w  = ce & ~pend_full_q;
    assign out_valid_w = ce & act_full_q;
    assign accept_w    = bus.in_valid & in_ready_w;
    assign xfer_w      = out_valid_w & bus.out_ready;
    assign end_xfer_w  = xfer_w & (idx_q == LAST_IDX);

    // Byte is driven from registered state only; zero while no word is held.
    assign out_data_w  = act_full_q ? byte_sel_w : 8'h00;

    always_comb begin
        act_d       = act_q;
        pend_d      = pend_q;
        idx_d       = idx_q;
        act_full_d  = act_full_q;
        pend_full_d = pend_full_q;

        if (xfer_w) begin
            if (!end_xfer_w) begin
                idx_d = idx_q + 4'd1;
            end else begin
                idx_d = 4'd0;
                if (pend_full_q) begin
                    act_d       = pend_q;
                    pend_full_d = 1'b0;
                end else if (accept_w) begin
                    act_d = bus.d;
                end else begin
                    act_full_d = 1'b0;
                end
            end
        end

        // An end-of-word transfer already consumed any same-cycle accept above.
        if (accept_w && !end_xfer_w) begin
            if (!act_full_q) begin
                act_d      = bus.d;
                act_full_d = 1'b1;
                idx_d      = 4'd0;
            end else begin
                pend_d      = bus.d;
                pend_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            act_q       <= '0;
            pend_q      <= '0;
            idx_q       <= '0;
            act_full_q  <= 1'b0;
            pend_full_q <= 1'b0;
        end else if (ce) begin
            act_q       <= act_d;
            pend_q      <= pend_d;
            idx_q       <= idx_d;
            act_full_q  <= act_full_d;
            pend_full_q <= pend_full_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = out_valid_w & (idx_q == LAST_IDX);

`ifdef REG9B_SER_PARITY_EN
    assign bus.out_par   = out_valid_w & (^out_data_w);
`endif

endmodule

// File: doc/reg9b_byte_serializer.md
Name: reg9b_byte_serializer

Overview:
- Reader-side companion to the 72-bit (9-byte) register.
- Accepts one 72-bit word through a valid/ready handshake and emits it as 9 sequential bytes on a byte-wide valid/ready stream.
- Holds one active word plus one pending word, so back-to-back words stream with no bubble.
- Sits between a 72-bit datapath register and any byte-oriented consumer.

Parameters:
- MSB_FIRST, 0, byte emission order. 0: byte 0 (d[7:0]) is first. 1: d[71:64] is first.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-low clear (0 = reset)
- ce  input  1  clock enable; 0 freezes all state
- d  input  72  word to serialize
- in_valid  input  1  d is valid
- in_ready  output  1  block can accept a word this cycle
- out_data  output  8  current byte
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data
- out_idx  output  4  index of current byte, 0..8
- out_last  output  1  current byte is byte 8

Behaviour:
- Reset (clr=0, asynchronous, any time including mid-word):
  - act_full=0, pend_full=0, idx=0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, in_ready=1.
  - Partial word is discarded.
- Storage: active register act[71:0] with idx[3:0] and act_full; pending register pend[71:0] with pend_full.
- in_ready = ce & ~pend_full. It is never combinationally dependent on in_valid, d or out_ready.
- Accept: in_valid & in_ready at a rising edge.
- Output stream:
  - out_valid = act_full & ce.
  - out_idx = idx; out_last = out_valid & (idx==8).
  - out_data selects byte idx per MSB_FIRST. It is registered, or muxed from registered state only.
  - Byte transfer: out_valid & out_ready.
- Holding: while out_valid=1 and out_ready=0, out_data, out_idx and out_last stay stable.
- Transfer with idx<8: idx increments by 1.
- Transfer with idx==8 (end of word), next state is the first match:
  - pend_full: act<=pend, idx<=0, pend_full<=0.
  - else accept same cycle: act<=d, idx<=0, act_full stays 1.
  - else: act_full<=0, idx<=0.
- Accept when not at end-of-word transfer:
  - act_full=0: act<=d, act_full<=1, idx<=0. First byte is valid the next cycle (latency 1).
  - act_full=1: pend<=d, pend_full<=1.
  - A simultaneous pend→act move and new accept cannot occur, because in_ready=0 when pend_full=1.
- Throughput: with out_ready held at 1, one byte per cycle. Consecutive words give 9k bytes with no idle cycle.
- ce=0:
  - No register updates; in_ready=0 and out_valid=0.
  - On ce returning to 1, the stream resumes at the same idx with the same data.
- Byte ordering, for byte k:
  - MSB_FIRST=0: d[8k+7:8k].
  - MSB_FIRST=1: d[71-8k:64-8k].

Optional Feature:
- Macro: REG9B_SER_PARITY_EN
- Defined:
  - Adds output port out_par (1 bit) = ^out_data (even parity: out_data plus out_par has even weight).
  - Valid only with out_valid; forced 0 while out_valid=0 and during reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: clr=0 with in_valid=1 -> in_ready=1, out_valid=0, out_data=0. Assert clr=0 at byte 4 -> next cycle out_valid=0, idx=0, and the next word restarts at byte 0.
- Single word, MSB_FIRST=0: d=72'h09_08_07_06_05_04_03_02_01, out_ready=1 -> out_data 01..09 on 9 consecutive cycles starting 1 cycle after accept; out_last only with 09; out_valid drops after.
- Back-to-back: words A=72'h11..19, B=72'h21..29 presented consecutively, out_ready=1 -> 18 consecutive bytes with no gap. in_ready=0 from the cycle after B is accepted until the cycle after A's last byte transfers.
- Backpressure: out_ready=0 for 3 cycles while idx=3 -> out_data=0x04 and out_idx=3 held, no byte lost or duplicated. Assert ce=0 for 2 cycles mid-word -> out_valid=0, then resumes at the same byte.
- MSB_FIRST=1 with the same word as the single-word test -> bytes 09,08,...,01; out_last with 01.
- With REG9B_SER_PARITY_EN: byte 0x07 -> out_par=1; byte 0x03 -> out_par=0; out_par=0 whenever out_valid=0.
